// File: rtl/eyeriss_pkg.sv
// Shared constants for the ifmap datapath: word/tag widths, GLB read latency,
// tag field positions and the stream FSM state encoding.
package eyeriss_pkg;

  localparam int IFMAP_DW         = 16;
  localparam int IFMAP_TW         = 9;
  localparam int GLB_RD_LAT       = 2;
  localparam int IFMAP_FIFO_DEPTH = 8;

  // Tag layout: {row[3:0], col[4:0]}
  localparam int ROW_TAG_MSB = 8;
  localparam int ROW_TAG_LSB = 5;
  localparam int COL_TAG_MSB = 4;
  localparam int COL_TAG_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } stream_state_e;

  // Build a tag from its row and column fields
  function automatic logic [IFMAP_TW-1:0] make_tag(input logic [3:0] row, input logic [4:0] col);
    logic [IFMAP_TW-1:0] t;
    t = '0;
    t[ROW_TAG_MSB:ROW_TAG_LSB] = row;
    t[COL_TAG_MSB:COL_TAG_LSB] = col;
    return t;
  endfunction

endpackage

// File: rtl/ifmap_glb_stream_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers. The head entry is read straight out of
// the register array, so a word written while empty shows up on the next cycle.
module sync_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_push_ok;
  logic         w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Storage array: written on accepted pushes only, contents need no reset
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  // Read/write pointers; the extra MSB distinguishes full from empty
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ifmap_glb_stream.sv
// Realigns loader slots with the GLB read return, zero-fills pad slots, buffers
// {tag, data} words and streams them to the X-bus with almost-full backpressure
// and a pass-done pulse once everything issued has been delivered.
module ifmap_glb_stream
  import eyeriss_pkg::*;
#(
  parameter int DW     = IFMAP_DW,
  parameter int TW     = IFMAP_TW,
  parameter int RD_LAT = GLB_RD_LAT,
  parameter int DEPTH  = IFMAP_FIFO_DEPTH
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_slot_valid,
  input  logic          i_glb_re,
  input  logic [TW-1:0] i_tag,
  input  logic [DW-1:0] i_glb_rdata,
  input  logic          i_load_done,
  output logic          o_almost_full,
  output logic          o_ifmap_valid,
  output logic [DW-1:0] o_ifmap_data,
  output logic [TW-1:0] o_ifmap_tag,
  input  logic          i_ifmap_ready,
  output logic          o_pass_done,
  output logic          o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;   // FIFO count width
  localparam int SW = AW + 2;   // count + in-flight width

  logic [RD_LAT-1:0] r_vld_pipe;
  logic [RD_LAT-1:0] r_re_pipe;
  logic [RD_LAT-1:0] r_done_pipe;
  logic              r_almost_full;
  logic              r_overflow;
  stream_state_e     r_state;
  stream_state_e     w_state_next;

  logic              w_tail_vld;
  logic              w_done_tail;
  logic [TW+DW-1:0]  w_wdata;
  logic [TW+DW-1:0]  w_head;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_count_next;
  logic [SW-1:0]     w_inflight_next;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_drained_next;

  assign w_tail_vld  = r_vld_pipe[RD_LAT-1];
  assign w_done_tail = r_done_pipe[RD_LAT-1];
  // Pad slots never touched the GLB, so whatever is on rdata is replaced by zero
  assign w_wdata     = {i_tag, (r_re_pipe[RD_LAT-1] ? i_glb_rdata : DW'(0))};
  assign w_pop       = o_ifmap_valid && i_ifmap_ready;
  assign w_push_ok   = w_tail_vld && (!w_full || w_pop);

  // Alignment pipe: request-timing controls delayed to line up with rdata/tag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_pipe  <= '0;
      r_re_pipe   <= '0;
      r_done_pipe <= '0;
    end else begin
      r_vld_pipe[0]  <= i_slot_valid;
      r_re_pipe[0]   <= i_glb_re;
      r_done_pipe[0] <= i_load_done;
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld_pipe[k]  <= r_vld_pipe[k-1];
        r_re_pipe[k]   <= r_re_pipe[k-1];
        r_done_pipe[k] <= r_done_pipe[k-1];
      end
    end
  end

  sync_fifo #(
    .W     (TW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_tail_vld),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign o_ifmap_valid = !w_empty;
  assign o_ifmap_data  = o_ifmap_valid ? w_head[DW-1:0] : '0;
  assign o_ifmap_tag   = o_ifmap_valid ? w_head[TW+DW-1:DW] : '0;
  assign o_almost_full = r_almost_full;
  assign o_overflow    = r_overflow;
  assign w_count_next  = w_count + CW'(w_push_ok) - CW'(w_pop);

  // Pipe occupancy after this edge: the new slot plus every stage not leaving the tail
  always_comb begin
    w_inflight_next = SW'(i_slot_valid);
    for (int k = 0; k < RD_LAT - 1; k++) begin
      w_inflight_next = w_inflight_next + SW'(r_vld_pipe[k]);
    end
  end

  assign w_drained_next = (w_count_next == '0) && (w_inflight_next == '0);

  // Almost-full and sticky overflow; almost-full reflects the state seen next cycle,
  // leaving exactly one free entry for the slot the loader may still issue
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_almost_full <= (SW'(w_count_next) + w_inflight_next) >= SW'(DEPTH - 1);
      if (w_tail_vld && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Pass FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pass FSM next state and pass-done output; drained checks use post-edge
  // occupancy so the pulse lands the cycle after the final pop
  always_comb begin
    w_state_next = r_state;
    o_pass_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_slot_valid) w_state_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_done_tail) w_state_next = w_drained_next ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_drained_next) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        o_pass_done  = 1'b1;
        // A slot issued during the pulse already belongs to the next pass
        w_state_next = i_slot_valid ? ST_STREAM : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifmap_glb_stream.sv
// Randomised bench for ifmap_glb_stream against a queue-based reference model:
// each issued slot becomes a word visible RD_LAT+1 cycles later, FIFO of DEPTH.
module tb_ifmap_glb_stream;
  import eyeriss_pkg::*;

  localparam int DW     = IFMAP_DW;
  localparam int TW     = IFMAP_TW;
  localparam int RD_LAT = GLB_RD_LAT;
  localparam int DEPTH  = IFMAP_FIFO_DEPTH;

  typedef struct {
    int            vis;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } word_t;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_slot_valid = 1'b0;
  logic          i_glb_re = 1'b0;
  logic [TW-1:0] i_tag = '0;
  logic [DW-1:0] i_glb_rdata = '0;
  logic          i_load_done = 1'b0;
  logic          i_ifmap_ready = 1'b0;
  logic          o_almost_full;
  logic          o_ifmap_valid;
  logic [DW-1:0] o_ifmap_data;
  logic [TW-1:0] o_ifmap_tag;
  logic          o_pass_done;
  logic          o_overflow;

  always #5 i_clk = ~i_clk;

  ifmap_glb_stream dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_slot_valid  (i_slot_valid),
    .i_glb_re      (i_glb_re),
    .i_tag         (i_tag),
    .i_glb_rdata   (i_glb_rdata),
    .i_load_done   (i_load_done),
    .o_almost_full (o_almost_full),
    .o_ifmap_valid (o_ifmap_valid),
    .o_ifmap_data  (o_ifmap_data),
    .o_ifmap_tag   (o_ifmap_tag),
    .i_ifmap_ready (i_ifmap_ready),
    .o_pass_done   (o_pass_done),
    .o_overflow    (o_overflow)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  word_t         pend_q[$];
  word_t         fifo_q[$];
  bit            m_ovf = 1'b0;
  logic [TW-1:0] hist_tag [8];
  logic [DW-1:0] hist_dat [8];
  int            first_valid_cyc = -1;
  int            pd_count = 0;
  int            pd_cyc = -1;
  int            dut_pops = 0;
  int            last_dut_pop = -1;
  bit            af_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive loader/GLB/X-bus inputs, compare outputs, advance model
  task automatic tick(input bit sv, input bit re, input logic [TW-1:0] tg,
                      input logic [DW-1:0] d, input bit ld, input bit rdy);
    int    idx;
    word_t w;
    idx           = (cyc - RD_LAT) & 7;
    i_slot_valid  = sv;
    i_glb_re      = re;
    i_load_done   = ld;
    i_ifmap_ready = rdy;
    i_tag         = hist_tag[idx];
    i_glb_rdata   = hist_dat[idx];
    hist_tag[cyc & 7] = tg;
    hist_dat[cyc & 7] = d;
    #1;
    chk("valid", 32'(o_ifmap_valid), 32'(fifo_q.size() > 0));
    if (fifo_q.size() > 0) begin
      chk("data", 32'(o_ifmap_data), 32'(fifo_q[0].data));
      chk("tag", 32'(o_ifmap_tag), 32'(fifo_q[0].tag));
    end
    chk("almost_full", 32'(o_almost_full), 32'((fifo_q.size() + pend_q.size()) >= DEPTH - 1));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    if (o_ifmap_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (o_pass_done) begin
      pd_count++;
      pd_cyc = cyc;
    end
    if (o_ifmap_valid && rdy) begin
      dut_pops++;
      last_dut_pop = cyc;
    end
    af_prev = o_almost_full;
    if (fifo_q.size() > 0 && rdy) begin
      w = fifo_q.pop_front();
      $display("cyc %0d word tag=%03h data=%04h", cyc, w.tag, w.data);
    end
    while (pend_q.size() > 0 && pend_q[0].vis == cyc + 1) begin
      w = pend_q.pop_front();
      if (fifo_q.size() < DEPTH) fifo_q.push_back(w);
      else m_ovf = 1'b1;
    end
    if (sv) begin
      w.vis  = cyc + RD_LAT + 1;
      w.tag  = tg;
      w.data = re ? d : '0;
      pend_q.push_back(w);
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    i_rst         = 1'b1;
    i_slot_valid  = 1'b0;
    i_glb_re      = 1'b0;
    i_load_done   = 1'b0;
    i_ifmap_ready = 1'b0;
    @(posedge i_clk);
    #1;
    cyc++;
    i_rst = 1'b0;
    fifo_q.delete();
    pend_q.delete();
    m_ovf   = 1'b0;
    af_prev = 1'b0;
    chk("rst_valid", 32'(o_ifmap_valid), 32'd0);
    chk("rst_almost_full", 32'(o_almost_full), 32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    chk("rst_pass_done", 32'(o_pass_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int c0;
    int p0;
    for (int k = 0; k < 8; k++) begin
      hist_tag[k] = '0;
      hist_dat[k] = '0;
    end

    // 6 real slots back to back, X-bus always ready
    do_reset();
    first_valid_cyc = -1;
    c0 = cyc;
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b1, make_tag(4'd1, 5'(k)), 16'h0101 + 16'(k), 1'b0, 1'b1);
    repeat (6) tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("first_valid_lat", 32'(first_valid_cyc - c0), 32'(RD_LAT + 1));

    // pad, real, pad with GLB returning 0xABCD every cycle
    for (int k = 0; k < 3; k++) tick(1'b1, (k == 1), make_tag(4'd2, 5'(k)), 16'hABCD, 1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b0, '0, 16'hABCD, 1'b0, 1'b1);

    // X-bus stalled, loader honours almost-full one cycle late
    for (int k = 0; k < 14; k++)
      tick(!af_prev, 1'b1, TW'($urandom), DW'($urandom), 1'b0, 1'b0);
    chk("fill_overflow", 32'(o_overflow), 32'd0);
    chk("fill_almost_full", 32'(o_almost_full), 32'd1);
    chk("fill_valid", 32'(o_ifmap_valid), 32'd1);
    repeat (12) tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);

    // Loader ignores almost-full: 12 slots into a stalled stream
    p0 = dut_pops;
    for (int k = 0; k < 12; k++) tick(1'b1, 1'b1, TW'($urandom), DW'($urandom), 1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (12) tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("ovf_sticky", 32'(o_overflow), 32'd1);
    chk("ovf_delivered", 32'(dut_pops - p0), 32'd8);

    // Load-done after the last slot, ready toggling
    do_reset();
    pd_count = 0;
    for (int k = 0; k < 6; k++)
      tick(1'b1, 1'b1, make_tag(4'd3, 5'(k)), DW'($urandom), 1'b0, cyc[0]);
    tick(1'b0, 1'b0, '0, '0, 1'b1, cyc[0]);
    repeat (20) tick(1'b0, 1'b0, '0, '0, 1'b0, cyc[0]);
    chk("pass_done_count", 32'(pd_count), 32'd1);
    chk("pass_done_cyc", 32'(pd_cyc), 32'(last_dut_pop + 1));

    // Reset with 5 words buffered, then resume
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, make_tag(4'd4, 5'(k)), DW'($urandom), 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    do_reset();
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, make_tag(4'd5, 5'(k)), DW'($urandom), 1'b0, 1'b1);
    repeat (6) tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);

    // Random traffic with a well-behaved loader
    for (int k = 0; k < 400; k++)
      tick(!af_prev && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           TW'($urandom), DW'($urandom), 1'b0, ($urandom_range(0, 2) != 0));
    repeat (12) tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("rand_overflow", 32'(o_overflow), 32'd0);
    chk("rand_drained", 32'(o_ifmap_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
